// File: rtl/setn_release_sequencer_if.sv
// Handshake and set-output bundle for setn_release_sequencer.
// Optional MASK signal present only when SETN_SEQ_MASK_EN is defined.
interface setn_release_sequencer_if #(
   parameter int GROUPS = 4
);
   logic              REQ;
`ifdef SETN_SEQ_MASK_EN
   logic [GROUPS-1:0] MASK;
`endif
   logic              ACK;
   logic              BUSY;
   logic              DONE;
   logic [GROUPS-1:0] SETN_OUT;

`ifdef SETN_SEQ_MASK_EN
   modport master (output REQ, output MASK, input ACK, input BUSY, input DONE, input SETN_OUT);
   modport slave  (input REQ, input MASK, output ACK, output BUSY, output DONE, output SETN_OUT);
`else
   modport master (output REQ, input ACK, input BUSY, input DONE, input SETN_OUT);
   modport slave  (input REQ, output ACK, output BUSY, output DONE, output SETN_OUT);
`endif
endinterface

// File: rtl/setn_release_sequencer.sv
// setn_release_sequencer: holds a bank of negative-edge set-flop groups in
// preset, then releases them one group per GAP_CYCLES so no two releases
// share an edge. All state changes on the falling edge of CLKN.
// Optional feature macro: SETN_SEQ_MASK_EN (adds MASK, selects which groups
// a requested sequence presets and releases).
module setn_release_sequencer #(
   parameter int GROUPS      = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 2
) (
   input  logic                      CLKN,
   input  logic                      RN,
   setn_release_sequencer_if.slave   bus
);
   localparam int IDX_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, FINISH} state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [GROUPS-1:0] setn_q, setn_d;
   logic [GROUPS-1:0] pend_q, pend_d;   // groups still waiting for release
   logic              ack_q, ack_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic [IDX_W-1:0]  nxt;
   logic [GROUPS-1:0] rem;
   logic              do_rel;

   // Lowest pending group index; release order is ascending.
   function automatic logic [IDX_W-1:0] lowest(input logic [GROUPS-1:0] v);
      lowest = '0;
      for (int i = GROUPS - 1; i >= 0; i--)
         if (v[i]) lowest = IDX_W'(i);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      sat_inc = (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      setn_d  = setn_q;
      pend_d  = pend_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;
      busy_d  = busy_q;
      do_rel  = 1'b0;
      nxt     = lowest(pend_q);
      rem     = pend_q;
      rem[nxt] = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            setn_d = '1;
            if (bus.REQ) begin
               ack_d   = 1'b1;
               busy_d  = 1'b1;
`ifdef SETN_SEQ_MASK_EN
               setn_d  = ~bus.MASK;
               pend_d  = bus.MASK;
`else
               setn_d  = '0;
               pend_d  = '1;
`endif
               cnt_d   = '0;
               idx_d   = '0;
               state_d = ASSERT;
            end
         end
         ASSERT: begin
            if (cnt_q >= 8'(HOLD_CYCLES - 1)) begin
               cnt_d  = '0;
               idx_d  = '0;
               do_rel = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         RELEASE: begin
            if (cnt_q >= 8'(GAP_CYCLES - 1)) begin
               cnt_d  = '0;
               do_rel = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Release the next pending group; finish once none remain, so masked
      // groups never cost gap time.
      if (do_rel) begin
         if (pend_q == '0) begin
            state_d = FINISH;
         end else begin
            setn_d[nxt] = 1'b1;
            pend_d      = rem;
            idx_d       = nxt;
            state_d     = (rem == '0) ? FINISH : RELEASE;
         end
      end
   end

   // State register; reset presets the whole bank and arms a full sequence.
   always_ff @(negedge CLKN or negedge RN) begin
      if (!RN) begin
         state_q <= ASSERT;
         cnt_q   <= '0;
         idx_q   <= '0;
         setn_q  <= '0;
         pend_q  <= '1;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         setn_q  <= setn_d;
         pend_q  <= pend_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.ACK      = ack_q;
   assign bus.BUSY     = busy_q;
   assign bus.DONE     = done_q;
   assign bus.SETN_OUT = setn_q;
endmodule

// File: tb/tb_setn_release_sequencer.sv
// Directed bench for setn_release_sequencer: a default instance (4 groups,
// hold 8, gap 2) and a minimal instance (1 group, hold 1).
module tb_setn_release_sequencer;
   localparam int G    = 4;
   localparam int HOLD = 8;
   localparam int GAP  = 2;
   localparam int LAT  = HOLD + (G - 1) * GAP + 1;   // 15

   logic clkn;
   logic rn;
   int   checks = 0;
   int   errors = 0;

   setn_release_sequencer_if #(.GROUPS(G)) bus ();
   setn_release_sequencer_if #(.GROUPS(1)) bus1 ();

   setn_release_sequencer #(.GROUPS(G), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
      .CLKN (clkn),
      .RN   (rn),
      .bus  (bus)
   );

   setn_release_sequencer #(.GROUPS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
      .CLKN (clkn),
      .RN   (rn),
      .bus  (bus1)
   );

   initial clkn = 1'b1;
   always #5 clkn = ~clkn;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clkn);
      #1;
   endtask

   // Full unmasked sequence, edge 0 being the ACK edge or the RN rise.
   task automatic check_seq(input string name);
      logic [G-1:0] exp_setn;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         for (int i = 0; i < G; i++) exp_setn[i] = (k >= HOLD + i * GAP);
         check($sformatf("%s setn k%0d", name, k), 32'(bus.SETN_OUT), 32'(exp_setn));
         check($sformatf("%s done k%0d", name, k), 32'(bus.DONE), 32'(k == LAT));
         check($sformatf("%s busy k%0d", name, k), 32'(bus.BUSY), 32'(k < LAT));
         check($sformatf("%s ack k%0d", name, k), 32'(bus.ACK), 32'd0);
      end
   endtask

   initial begin
      rn = 1'b1;
      bus.REQ = 1'b0;
      bus1.REQ = 1'b0;
`ifdef SETN_SEQ_MASK_EN
      bus.MASK = '1;
      bus1.MASK = '1;
`endif
      #2 rn = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("rst setn", 32'(bus.SETN_OUT), 32'h0);
      check("rst busy", 32'(bus.BUSY), 32'd1);
      check("rst ack", 32'(bus.ACK), 32'd0);
      check("rst done", 32'(bus.DONE), 32'd0);
      check("rst setn1", 32'(bus1.SETN_OUT), 32'h0);
      rn = 1'b1;
      check_seq("rst");
      tick();
      check("idle setn", 32'(bus.SETN_OUT), 32'hF);
      check("idle busy", 32'(bus.BUSY), 32'd0);

      // Single-cycle request.
      bus.REQ = 1'b1;
      tick();
      bus.REQ = 1'b0;
      check("req ack", 32'(bus.ACK), 32'd1);
      check("req setn", 32'(bus.SETN_OUT), 32'h0);
      check("req busy", 32'(bus.BUSY), 32'd1);
      check_seq("req");
      tick();
      check("req idle ack", 32'(bus.ACK), 32'd0);

      // REQ held high: ignored while busy, re-accepted one edge after DONE.
      bus.REQ = 1'b1;
      tick();
      check("hold ack1", 32'(bus.ACK), 32'd1);
      check_seq("hold");
      tick();
      check("hold ack2", 32'(bus.ACK), 32'd1);
      check("hold setn2", 32'(bus.SETN_OUT), 32'h0);
      bus.REQ = 1'b0;
      check_seq("hold2");
      tick();

      // Mid-sequence reset after group 1 released.
      bus.REQ = 1'b1;
      tick();
      bus.REQ = 1'b0;
      check("mid ack", 32'(bus.ACK), 32'd1);
      for (int k = 1; k <= HOLD + GAP; k++) tick();
      check("mid pre", 32'(bus.SETN_OUT), 32'h3);
      #2 rn = 1'b0;
      #1;
      check("mid async setn", 32'(bus.SETN_OUT), 32'h0);
      check("mid async busy", 32'(bus.BUSY), 32'd1);
      tick();
      tick();
      rn = 1'b1;
      check_seq("mid");
      tick();

      // Minimal instance: GROUPS=1, HOLD=1.
      check("g1 idle busy", 32'(bus1.BUSY), 32'd0);
      bus1.REQ = 1'b1;
      tick();
      bus1.REQ = 1'b0;
      check("g1 ack", 32'(bus1.ACK), 32'd1);
      check("g1 setn0", 32'(bus1.SETN_OUT), 32'h0);
      tick();
      check("g1 rel", 32'(bus1.SETN_OUT), 32'h1);
      check("g1 nodone", 32'(bus1.DONE), 32'd0);
      tick();
      check("g1 done", 32'(bus1.DONE), 32'd1);
      check("g1 busy", 32'(bus1.BUSY), 32'd0);

`ifdef SETN_SEQ_MASK_EN
      // Masked sequence: only groups 1 and 3.
      bus.MASK = 4'b1010;
      bus.REQ = 1'b1;
      tick();
      bus.REQ = 1'b0;
      bus.MASK = 4'b1111;
      check("mask ack", 32'(bus.ACK), 32'd1);
      check("mask setn0", 32'(bus.SETN_OUT), 32'h5);
      for (int k = 1; k <= HOLD + GAP + 1; k++) begin
         tick();
         check($sformatf("mask setn k%0d", k), 32'(bus.SETN_OUT),
               32'h5 | (k >= HOLD ? 32'h2 : 32'h0) | (k >= HOLD + GAP ? 32'h8 : 32'h0));
         check($sformatf("mask done k%0d", k), 32'(bus.DONE), 32'(k == HOLD + GAP + 1));
      end
      tick();
      // Empty mask: DONE after HOLD+1 edges, outputs untouched.
      bus.MASK = 4'b0000;
      bus.REQ = 1'b1;
      tick();
      bus.REQ = 1'b0;
      check("mask0 ack", 32'(bus.ACK), 32'd1);
      for (int k = 1; k <= HOLD + 1; k++) begin
         tick();
         check($sformatf("mask0 setn k%0d", k), 32'(bus.SETN_OUT), 32'hF);
         check($sformatf("mask0 done k%0d", k), 32'(bus.DONE), 32'(k == HOLD + 1));
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
